r_format_pipe: RTL and testbench
================================

// Module: r_format_pipe
// PURPOSE
//  Next-generation R-format core: 3-stage pipeline (DECODE/RF-read -> EX -> WB) with internal PC,
//  parametrised register file and datapath width, full EX/WB forwarding (no stalls).
//  Instruction words arrive over a valid/ready handshake; each accepted word advances the PC.
//  Retired writes are exported on a WB port for the test harness / debug mux.
// PARAMETERS
//  DATA_W    32  datapath/register width; power of 2, 8..64
//  NUM_REGS  32  architectural registers, 2..32; r0 hardwired to 0
//  PC_W      32  PC width; PC wraps mod 2^PC_W
//  PC_STEP    4  PC increment per accepted instruction
//  RESET_PC   0  PC value after reset
// PORTS
//  clk          in   1            sole clock, rising edge
//  reset        in   1            async, active-high; clears all state
//  hold         in   1            freeze whole pipeline (PC, stage regs, RF)
//  instr_valid  in   1            instr holds a word to execute
//  instr_ready  out  1            = ~hold && ~reset
//  instr        in   32           MIPS-encoded instruction
//  pc           out  PC_W         address of next instruction to fetch
//  wb_valid     out  1            retirement this cycle (RF written at next edge)
//  wb_addr      out  5            destination register of retiring instr
//  wb_data      out  DATA_W       value written
//  dbg_raddr    in   5            debug read address (combinational)
//  dbg_rdata    out  DATA_W       RF[dbg_raddr]; 0 if addr 0 or >= NUM_REGS
//  ovf_flag     out  1            sticky overflow flag (only with OVF_TRAP_EN)
// BEHAVIOUR
//  Reset: pc=RESET_PC; all RF entries 0; stage valids 0; wb_valid/wb_addr/wb_data 0; ovf_flag 0.
//  Accept = instr_valid && instr_ready. On accept: pc <= pc+PC_STEP (wrap), decoded instr enters EX.
//  Decode: opcode[31:26]!=0 -> bubble (accepted, PC advances, no write). rd=0 or rd>=NUM_REGS -> no write.
//  Funct: 20 add,21 addu,22 sub,23 subu,24 and,25 or,26 xor,27 nor,2A slt(signed),2B sltu,
//   00 sll,02 srl,03 sra (amount shamt), 04 sllv,06 srlv,07 srav (amount rs[log2(DATA_W)-1:0]).
//   Other funct -> bubble. Fixed shift amount = shamt mod DATA_W. slt/sltu result zero-extended 0/1.
//  Arithmetic modulo 2^DATA_W; add/sub without OVF_TRAP_EN behave as addu/subu.
//  Latency: accepted at edge t -> EX during cycle t..t+1 -> wb_valid high cycle t+1..t+2 -> RF write edge t+2.
//  Throughput 1 instr/cycle. Operand read in decode with forwarding priority EX result > WB > RF;
//   source reg 0 or >= NUM_REGS always reads 0, never forwarded.
//  hold=1: no accept, all regs/PC/RF unchanged, wb_valid forced 0; resumes exactly where frozen.
//  instr_valid=0 (no hold): bubble enters EX; in-flight instructions continue draining.
//  Reset mid-stream: in-flight instructions discarded, no RF write after reset asserts.
//  dbg_rdata shows RF state only (no forwarding); same-cycle write visible next cycle.
// CONFIGURATION
//  OVF_TRAP_EN defined: signed overflow on add(20)/sub(22) suppresses RF write (wb_valid=0 for it)
//   and sets ovf_flag (sticky until reset); younger instructions still execute.
//  OVF_TRAP_EN undefined: add/sub wrap silently; ovf_flag tied 0.
// TESTING
//  1 Reset then idle -> pc=0, wb_valid=0, dbg_rdata=0 for all addrs; 3 accepts -> pc=12.
//  2 RF preloaded via addu chain: r1=5,r2=3 then sub r3,r1,r2 -> wb_data=2 at t+1, dbg r3=2 after t+2.
//  3 Back-to-back dependents: addu r4,r1,r2; addu r5,r4,r4; or r6,r5,r4 -> r4=8,r5=16,r6=24 (EX/WB fwd).
//  4 Shifts: r1=0x80000000: sra r7,r1,4 -> 0xF8000000; srl -> 0x08000000; slt r8,r1,r2 -> 1, sltu -> 0.
//  5 Writes to r0 and bad opcode 0x23 -> no wb_valid, r0 reads 0; hold 3 cycles mid-stream -> pc/results unchanged.
//  6 OVF_TRAP_EN: add 0x7FFFFFFF+1 -> no write, ovf_flag=1 sticky; undefined -> result 0x80000000 written.

Source files
------------

// File: rtl/r_format_pipe.sv
// r_format_pipe: 3-stage R-format core (decode/RF-read -> EX -> WB) with full EX/WB forwarding.
// Optional feature macro OVF_TRAP_EN: signed overflow on add/sub suppresses the write and sets sticky ovf_flag.
module r_format_pipe #(
  parameter int unsigned     DATA_W   = 32,
  parameter int unsigned     NUM_REGS = 32,
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     PC_STEP  = 4,
  parameter longint unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [PC_W-1:0]   pc,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ovf_flag
);

  localparam int SHW = $clog2(DATA_W);
  localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA
  } aluOp_e;

  function automatic logic regOk(input logic [4:0] a);
    return (a != 5'd0) && ({27'd0, a} < NUM_REGS);
  endfunction

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic              exValid_q, exValid_d;
  logic              exWrite_q, exWrite_d;
  aluOp_e            exOp_q, exOp_d;
  logic [4:0]        exRd_q, exRd_d;
  logic [DATA_W-1:0] exA_q, exA_d;
  logic [DATA_W-1:0] exB_q, exB_d;
  logic [SHW-1:0]    exSh_q, exSh_d;

  logic              wbValid_q, wbValid_d;
  logic [4:0]        wbAddr_q, wbAddr_d;
  logic [DATA_W-1:0] wbData_q, wbData_d;

  logic              accept;
  logic [4:0]        rs, rt, rd;
  logic [5:0]        funct;
  logic [DATA_W-1:0] rsVal, rtVal;
  logic              decValid;
  aluOp_e            decOp;
  logic [SHW-1:0]    decSh;
  logic [DATA_W-1:0] exResult;
  logic              exOvf;
  logic              exWe;

  assign instr_ready = ~hold & ~reset;
  assign accept      = instr_valid & instr_ready;
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign funct       = instr[5:0];

  // Operand fetch: the instruction in EX is youngest, so its result beats WB, which beats the RF.
  always_comb begin
    rsVal = '0;
    if (regOk(rs)) begin
      if (exWe && exRd_q == rs)              rsVal = exResult;
      else if (wbValid_q && wbAddr_q == rs)  rsVal = wbData_q;
      else                                   rsVal = rf_q[rs[RIW-1:0]];
    end
    rtVal = '0;
    if (regOk(rt)) begin
      if (exWe && exRd_q == rt)              rtVal = exResult;
      else if (wbValid_q && wbAddr_q == rt)  rtVal = wbData_q;
      else                                   rtVal = rf_q[rt[RIW-1:0]];
    end
  end

  always_comb begin
    decValid = (instr[31:26] == 6'd0);
    decOp    = OP_ADDU;
    decSh    = SHW'({1'b0, instr[10:6]} & 6'(DATA_W - 1));
    unique case (funct)
      6'h20: decOp = OP_ADD;
      6'h21: decOp = OP_ADDU;
      6'h22: decOp = OP_SUB;
      6'h23: decOp = OP_SUBU;
      6'h24: decOp = OP_AND;
      6'h25: decOp = OP_OR;
      6'h26: decOp = OP_XOR;
      6'h27: decOp = OP_NOR;
      6'h2A: decOp = OP_SLT;
      6'h2B: decOp = OP_SLTU;
      6'h00: decOp = OP_SLL;
      6'h02: decOp = OP_SRL;
      6'h03: decOp = OP_SRA;
      6'h04: begin decOp = OP_SLL; decSh = rsVal[SHW-1:0]; end
      6'h06: begin decOp = OP_SRL; decSh = rsVal[SHW-1:0]; end
      6'h07: begin decOp = OP_SRA; decSh = rsVal[SHW-1:0]; end
      default: decValid = 1'b0;
    endcase
  end

  // Shifts always operate on rt, which decode places in B.
  always_comb begin
    exResult = '0;
    unique case (exOp_q)
      OP_ADD, OP_ADDU: exResult = exA_q + exB_q;
      OP_SUB, OP_SUBU: exResult = exA_q - exB_q;
      OP_AND:          exResult = exA_q & exB_q;
      OP_OR:           exResult = exA_q | exB_q;
      OP_XOR:          exResult = exA_q ^ exB_q;
      OP_NOR:          exResult = ~(exA_q | exB_q);
      OP_SLT:          exResult = {{(DATA_W-1){1'b0}}, $signed(exA_q) < $signed(exB_q)};
      OP_SLTU:         exResult = {{(DATA_W-1){1'b0}}, exA_q < exB_q};
      OP_SLL:          exResult = exB_q << exSh_q;
      OP_SRL:          exResult = exB_q >> exSh_q;
      OP_SRA:          exResult = DATA_W'($signed(exB_q) >>> exSh_q);
      default:         exResult = '0;
    endcase
  end

`ifdef OVF_TRAP_EN
  logic ovf_q, ovf_d;
  logic addOvf, subOvf;

  always_comb begin
    addOvf = (exA_q[DATA_W-1] == exB_q[DATA_W-1]) && (exResult[DATA_W-1] != exA_q[DATA_W-1]);
    subOvf = (exA_q[DATA_W-1] != exB_q[DATA_W-1]) && (exResult[DATA_W-1] != exA_q[DATA_W-1]);
    exOvf  = exValid_q && ((exOp_q == OP_ADD && addOvf) || (exOp_q == OP_SUB && subOvf));
    ovf_d  = ovf_q;
    if (!hold) ovf_d = ovf_q | exOvf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_flag = ovf_q;
`else
  assign exOvf    = 1'b0;
  assign ovf_flag = 1'b0;
`endif

  assign exWe = exValid_q & exWrite_q & ~exOvf;

  always_comb begin
    pc_d      = pc_q;
    exValid_d = exValid_q;
    exWrite_d = exWrite_q;
    exOp_d    = exOp_q;
    exRd_d    = exRd_q;
    exA_d     = exA_q;
    exB_d     = exB_q;
    exSh_d    = exSh_q;
    wbValid_d = wbValid_q;
    wbAddr_d  = wbAddr_q;
    wbData_d  = wbData_q;
    if (!hold) begin
      wbValid_d = exWe;
      wbAddr_d  = exWe ? exRd_q : 5'd0;
      wbData_d  = exWe ? exResult : '0;
      exValid_d = accept && decValid;
      exWrite_d = regOk(rd);
      exOp_d    = decOp;
      exRd_d    = rd;
      exA_d     = rsVal;
      exB_d     = rtVal;
      exSh_d    = decSh;
      if (accept) pc_d = pc_q + PC_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= PC_W'(RESET_PC);
      exValid_q <= 1'b0;
      exWrite_q <= 1'b0;
      exOp_q    <= OP_ADDU;
      exRd_q    <= 5'd0;
      exA_q     <= '0;
      exB_q     <= '0;
      exSh_q    <= '0;
      wbValid_q <= 1'b0;
      wbAddr_q  <= 5'd0;
      wbData_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      exValid_q <= exValid_d;
      exWrite_q <= exWrite_d;
      exOp_q    <= exOp_d;
      exRd_q    <= exRd_d;
      exA_q     <= exA_d;
      exB_q     <= exB_d;
      exSh_q    <= exSh_d;
      wbValid_q <= wbValid_d;
      wbAddr_q  <= wbAddr_d;
      wbData_q  <= wbData_d;
    end
  end

  // wbValid_q is only ever set for in-range, nonzero destinations, so the index is always legal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
    end else if (!hold && wbValid_q) begin
      rf_q[wbAddr_q[RIW-1:0]] <= wbData_q;
    end
  end

  assign pc        = pc_q;
  assign wb_valid  = wbValid_q & ~hold;
  assign wb_addr   = wbAddr_q;
  assign wb_data   = wbData_q;
  assign dbg_rdata = regOk(dbg_raddr) ? rf_q[dbg_raddr[RIW-1:0]] : '0;

endmodule

// File: tb/tb_r_format_pipe.sv
// tb_r_format_pipe: directed + random stimulus against an architectural (program-order) model of r_format_pipe.
module tb_r_format_pipe;

  logic        clk = 1'b0;
  logic        reset, hold, instrValid, instrReady;
  logic [31:0] instr, pc;
  logic        wbValid;
  logic [4:0]  wbAddr, dbgAddr;
  logic [31:0] wbData, dbgRdata;
  logic        ovfFlag;

  r_format_pipe dut (
    .clk(clk), .reset(reset), .hold(hold), .instr_valid(instrValid), .instr_ready(instrReady),
    .instr(instr), .pc(pc), .wb_valid(wbValid), .wb_addr(wbAddr), .wb_data(wbData),
    .dbg_raddr(dbgAddr), .dbg_rdata(dbgRdata), .ovf_flag(ovfFlag)
  );

  always #5 clk = ~clk;

  typedef struct packed { bit v; bit [4:0] a; bit [31:0] d; } retire_t;

  // Retirement pipe: [0] is what WB presents now, [1] is what will retire one cycle later.
  retire_t     pipeQ[$];
  bit [31:0]   archRf[32];
  bit [31:0]   commitRf[32];
  bit [31:0]   mPc;
  bit          mOvf;
  int          compared = 0;
  int          mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin archRf[i] = 0; commitRf[i] = 0; end
    mPc  = 0;
    mOvf = 0;
    pipeQ.delete();
    pipeQ.push_back('0);
    pipeQ.push_back('0);
  endtask

  // Executes one instruction in program order on the architectural register state.
  task automatic modelExec(input bit [31:0] ins, output retire_t r);
    bit [4:0]  rsA, rtA, rdA, sh;
    bit [31:0] a, b, res;
    longint    s;
    bit        ok, ovf;
    r = '0; ok = 1; ovf = 0; res = 0; s = 0;
    rsA = ins[25:21]; rtA = ins[20:16]; rdA = ins[15:11]; sh = ins[10:6];
    if (ins[31:26] != 0) return;
    a = archRf[rsA];
    b = archRf[rtA];
    case (ins[5:0])
      6'h20: begin res = a + b; s = longint'($signed(a)) + longint'($signed(b)); ovf = (s != longint'($signed(res))); end
      6'h21: res = a + b;
      6'h22: begin res = a - b; s = longint'($signed(a)) - longint'($signed(b)); ovf = (s != longint'($signed(res))); end
      6'h23: res = a - b;
      6'h24: res = a & b;
      6'h25: res = a | b;
      6'h26: res = a ^ b;
      6'h27: res = ~(a | b);
      6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: res = (a < b) ? 32'd1 : 32'd0;
      6'h00: res = b << sh;
      6'h02: res = b >> sh;
      6'h03: res = 32'($signed(b) >>> sh);
      6'h04: res = b << a[4:0];
      6'h06: res = b >> a[4:0];
      6'h07: res = 32'($signed(b) >>> a[4:0]);
      default: ok = 0;
    endcase
    if (!ok) return;
`ifdef OVF_TRAP_EN
    if (ovf) begin mOvf = 1; return; end
`else
    if (ovf) res = res;
`endif
    if (rdA == 0) return;
    archRf[rdA] = res;
    r = '{v: 1'b1, a: rdA, d: res};
  endtask

  task automatic checkCycle();
    retire_t cur;
    cur = pipeQ[0];
    checkOutput("pc", pc, mPc);
    checkOutput("instr_ready", 32'(instrReady), 32'(!hold));
    checkOutput("wb_valid", 32'(wbValid), 32'(cur.v && !hold));
    if (cur.v && !hold) begin
      checkOutput("wb_addr", 32'(wbAddr), 32'(cur.a));
      checkOutput("wb_data", wbData, cur.d);
    end
    checkOutput("ovf_flag", 32'(ovfFlag), 32'(mOvf));
    checkOutput("dbg_rdata", dbgRdata, commitRf[dbgAddr]);
  endtask

  // One clock: drive inputs at the negedge, advance the model, check at the following negedge.
  task automatic applyStimulus(input bit h, input bit v, input bit [31:0] ins);
    retire_t out, nw;
    hold = h; instrValid = v; instr = ins;
    if (!h) begin
      out = pipeQ.pop_front();
      if (out.v) commitRf[out.a] = out.d;
      nw = '0;
      if (v) begin modelExec(ins, nw); mPc += 4; end
      pipeQ.push_back(nw);
    end
    @(posedge clk);
    @(negedge clk);
    checkCycle();
    dbgAddr = 5'($urandom_range(0, 31));
  endtask

  task automatic dbgCheck(input string tag, input bit [4:0] addr, input bit [31:0] exp);
    dbgAddr = addr;
    #1;
    checkOutput(tag, dbgRdata, exp);
  endtask

  function automatic bit [31:0] rtype(input bit [5:0] fn, input bit [4:0] rd, input bit [4:0] rs,
                                      input bit [4:0] rt, input bit [4:0] sh = 5'd0);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic bit [31:0] randInstr();
    bit [5:0] fns[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    int       sel;
    bit [5:0] fn;
    bit [5:0] opc;
    sel = $urandom_range(0, 19);
    opc = 6'd0;
    fn  = fns[$urandom_range(0, 15)];
    if (sel == 0) opc = 6'($urandom_range(1, 63));
    if (sel == 1) fn  = 6'($urandom_range(0, 63));
    return {opc, 5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)),
            5'($urandom_range(0, 31)), fn};
  endfunction

  task automatic drain();
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
  endtask

  initial begin
    reset = 1; hold = 0; instrValid = 0; instr = 0; dbgAddr = 0;
    modelReset();
    @(negedge clk);
    #1;
    checkOutput("rst_ready", 32'(instrReady), 32'd0);
    @(negedge clk);
    reset = 0;
    #1;
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_wb_valid", 32'(wbValid), 32'd0);
    checkOutput("rst_ovf", 32'(ovfFlag), 32'd0);
    for (int i = 0; i < 32; i++) dbgCheck("rst_dbg", 5'(i), 32'd0);

    for (int i = 0; i < 3; i++) applyStimulus(0, 1, rtype(6'h21, 0, 0, 0));
    checkOutput("t1_pc12", pc, 32'd12);

    // Build constants from the all-zero RF: r20=~0, r21=1, r1=5, r2=3 (back-to-back dependents).
    applyStimulus(0, 1, rtype(6'h27, 20, 0, 0));
    applyStimulus(0, 1, rtype(6'h23, 21, 0, 20));
    applyStimulus(0, 1, rtype(6'h00, 22, 0, 21, 2));
    applyStimulus(0, 1, rtype(6'h21, 1, 22, 21));
    applyStimulus(0, 1, rtype(6'h00, 23, 0, 21, 1));
    applyStimulus(0, 1, rtype(6'h21, 2, 23, 21));
    applyStimulus(0, 1, rtype(6'h22, 3, 1, 2));
    applyStimulus(0, 0, 0);
    checkOutput("t2_wb_data", wbData, 32'd2);
    applyStimulus(0, 0, 0);
    dbgCheck("t2_r3", 3, 32'd2);

    applyStimulus(0, 1, rtype(6'h21, 4, 1, 2));
    applyStimulus(0, 1, rtype(6'h21, 5, 4, 4));
    applyStimulus(0, 1, rtype(6'h25, 6, 5, 4));
    drain();
    dbgCheck("t3_r4", 4, 32'd8);
    dbgCheck("t3_r5", 5, 32'd16);
    dbgCheck("t3_r6", 6, 32'd24);

    applyStimulus(0, 1, rtype(6'h00, 1, 0, 21, 31));
    applyStimulus(0, 1, rtype(6'h03, 7, 0, 1, 4));
    applyStimulus(0, 1, rtype(6'h02, 9, 0, 1, 4));
    applyStimulus(0, 1, rtype(6'h2A, 8, 1, 2));
    applyStimulus(0, 1, rtype(6'h2B, 10, 1, 2));
    drain();
    dbgCheck("t4_sra", 7, 32'hF8000000);
    dbgCheck("t4_srl", 9, 32'h08000000);
    dbgCheck("t4_slt", 8, 32'd1);
    dbgCheck("t4_sltu", 10, 32'd0);

    applyStimulus(0, 1, rtype(6'h21, 0, 1, 2));
    applyStimulus(0, 1, {6'h23, 5'd1, 5'd2, 5'd11, 5'd0, 6'h21});
    applyStimulus(0, 1, rtype(6'h21, 12, 2, 2));
    applyStimulus(1, 1, rtype(6'h21, 13, 2, 2));
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, rtype(6'h21, 14, 2, 2));
    applyStimulus(0, 1, rtype(6'h21, 13, 12, 2));
    drain();
    dbgCheck("t5_r0", 0, 32'd0);
    dbgCheck("t5_r11", 11, 32'd0);
    dbgCheck("t5_r13", 13, 32'd9);
    dbgCheck("t5_r14", 14, 32'd0);

    applyStimulus(0, 1, rtype(6'h02, 15, 0, 20, 1));
    applyStimulus(0, 1, rtype(6'h20, 16, 15, 21));
    drain();
`ifdef OVF_TRAP_EN
    dbgCheck("t6_r16", 16, 32'd0);
    checkOutput("t6_ovf", 32'(ovfFlag), 32'd1);
`else
    dbgCheck("t6_r16", 16, 32'h80000000);
    checkOutput("t6_ovf", 32'(ovfFlag), 32'd0);
`endif

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0, randInstr());

    // Asynchronous reset between edges with instructions in flight.
    applyStimulus(0, 1, rtype(6'h21, 17, 21, 21));
    applyStimulus(0, 1, rtype(6'h21, 18, 21, 21));
    #2 reset = 1;
    #1;
    checkOutput("mid_rst_pc", pc, 32'd0);
    checkOutput("mid_rst_wb_valid", 32'(wbValid), 32'd0);
    checkOutput("mid_rst_ready", 32'(instrReady), 32'd0);
    @(negedge clk);
    reset = 0;
    modelReset();
    dbgCheck("mid_rst_r17", 17, 32'd0);
    dbgCheck("mid_rst_r18", 18, 32'd0);
    for (int i = 0; i < 60; i++)
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0, randInstr());
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
